// File: rtl/magma_cbc_ctrl_if.sv
// Stream and cipher-core signal bundle for the Magma CBC chaining controller.
// A transfer happens on a rising edge where valid and ready are both high; valid holds with its payload until then.
interface magma_cbc_ctrl_if;
  logic        mode_encr;
  logic [63:0] iv;
  logic        iv_load;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic        core_start;
  logic [63:0] core_data_in;
  logic        core_encr_decr;
  logic [63:0] core_data_out;
  logic        core_done;
  logic        busy;
  logic        error;

  modport slave (
    input  mode_encr, iv, iv_load, in_valid, in_data, in_last, out_ready,
           core_data_out, core_done,
    output in_ready, out_valid, out_data, out_last, core_start, core_data_in,
           core_encr_decr, busy, error
  );

  modport master (
    output mode_encr, iv, iv_load, in_valid, in_data, in_last, out_ready,
           core_data_out, core_done,
    input  in_ready, out_valid, out_data, out_last, core_start, core_data_in,
           core_encr_decr, busy, error
  );
endinterface

// File: rtl/magma_cbc_ctrl.sv
// CBC chaining controller in front of a Magma block-cipher core: one block in flight,
// XOR/chain with IV or previous ciphertext, watchdog on the core's done.
module magma_cbc_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  magma_cbc_ctrl_if.slave  bus,
  output logic [1:0]       dbg_state,
  output logic [63:0]      dbg_chain
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [63:0] iv_reg_q, iv_reg_d;
  logic [63:0] chain_q, chain_d;
  logic [63:0] c_hold_q, c_hold_d;
  logic [63:0] core_data_in_q, core_data_in_d;
  logic        core_encr_decr_q, core_encr_decr_d;
  logic        core_start_q, core_start_d;
  logic [63:0] out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        error_q, error_d;
  logic [7:0]  wdog_q, wdog_d;

  always_comb begin
    state_d          = state_q;
    iv_reg_d         = iv_reg_q;
    chain_d          = chain_q;
    c_hold_d         = c_hold_q;
    core_data_in_d   = core_data_in_q;
    core_encr_decr_d = core_encr_decr_q;
    core_start_d     = 1'b0;
    out_data_d       = out_data_q;
    out_last_d       = out_last_q;
    out_valid_d      = out_valid_q;
    error_d          = error_q;
    wdog_d           = wdog_q;

    case (state_q)
      S_IDLE: begin
        // iv_load takes priority; the block offered in the same cycle stays pending
        if (bus.iv_load) begin
          iv_reg_d = bus.iv;
          chain_d  = bus.iv;
          error_d  = 1'b0;
        end else if (bus.in_valid) begin
          state_d          = S_START;
          core_start_d     = 1'b1;
          out_last_d       = bus.in_last;
          core_encr_decr_d = bus.mode_encr;
          c_hold_d         = bus.in_data;
          core_data_in_d   = bus.mode_encr ? (bus.in_data ^ chain_q) : bus.in_data;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        wdog_d  = 8'd0;
      end
      S_WAIT: begin
        // core_done is still stale in the first WAIT cycle (wdog_q == 0)
        if ((wdog_q != 8'd0) && bus.core_done) begin
          state_d     = S_OUT;
          out_valid_d = 1'b1;
          if (core_encr_decr_q) begin
            out_data_d = bus.core_data_out;
            chain_d    = bus.core_data_out;
          end else begin
            out_data_d = bus.core_data_out ^ chain_q;
            chain_d    = c_hold_q;
          end
        end else if (wdog_q == WDOG_LAST) begin
          state_d = S_IDLE;
          error_d = 1'b1;
          chain_d = iv_reg_q;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          if (out_last_q) chain_d = iv_reg_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      iv_reg_q         <= 64'd0;
      chain_q          <= 64'd0;
      c_hold_q         <= 64'd0;
      core_data_in_q   <= 64'd0;
      core_encr_decr_q <= 1'b0;
      core_start_q     <= 1'b0;
      out_data_q       <= 64'd0;
      out_last_q       <= 1'b0;
      out_valid_q      <= 1'b0;
      in_ready_q       <= 1'b1;
      busy_q           <= 1'b0;
      error_q          <= 1'b0;
      wdog_q           <= 8'd0;
    end else begin
      state_q          <= state_d;
      iv_reg_q         <= iv_reg_d;
      chain_q          <= chain_d;
      c_hold_q         <= c_hold_d;
      core_data_in_q   <= core_data_in_d;
      core_encr_decr_q <= core_encr_decr_d;
      core_start_q     <= core_start_d;
      out_data_q       <= out_data_d;
      out_last_q       <= out_last_d;
      out_valid_q      <= out_valid_d;
      in_ready_q       <= in_ready_d;
      busy_q           <= busy_d;
      error_q          <= error_d;
      wdog_q           <= wdog_d;
    end
  end

  assign bus.in_ready       = in_ready_q & ~bus.iv_load;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_last       = out_last_q;
  assign bus.core_start     = core_start_q;
  assign bus.core_data_in   = core_data_in_q;
  assign bus.core_encr_decr = core_encr_decr_q;
  assign bus.busy           = busy_q;
  assign bus.error          = error_q;
  assign dbg_state          = state_q;
  assign dbg_chain          = chain_q;

endmodule

// File: tb/tb_magma_cbc_ctrl.sv
// Directed bench for magma_cbc_ctrl: a behavioural Magma core stub plus hand-derived
// CBC expectations pushed through an expected-value queue.
module tb_magma_cbc_ctrl;

  localparam logic [255:0] KEY =
    256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam int PI [8][16] = '{
    '{12, 4, 6, 2,10, 5,11, 9,14, 8,13, 7, 0, 3,15, 1},
    '{ 6, 8, 2, 3, 9,10, 5,12, 1,14, 4, 7,11,13, 0,15},
    '{11, 3, 5, 8, 2,15,10,13,14, 1, 7, 4,12, 9, 6, 0},
    '{12, 8, 2, 1,13, 4,15, 6, 7, 0,10, 5, 3,14, 9,11},
    '{ 7,15, 5,10, 8, 1, 6,13, 0, 9, 3,14,11, 4, 2,12},
    '{ 5,13,15, 6, 9, 2,12,10,11, 7, 8, 1, 4, 3,14, 0},
    '{ 8,14, 2, 5, 6, 9, 1,12,15, 4,11, 0,13,10, 3, 7},
    '{ 1, 7,14,13, 0, 5, 8, 3, 4,15,10, 6, 9,12,11, 2}
  };

  logic clk;
  logic reset;
  logic [1:0]  dbg_state;
  logic [63:0] dbg_chain;

  magma_cbc_ctrl_if bus();

  magma_cbc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_chain (dbg_chain)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end, expected end of run");
    $fatal(1);
  end

  // ---------------- Magma reference model ----------------
  function automatic logic [31:0] g_fn(input logic [31:0] k, input logic [31:0] a);
    logic [31:0] s;
    logic [31:0] t;
    s = a + k;
    for (int i = 0; i < 8; i++) t[4*i +: 4] = 4'(PI[i][s[4*i +: 4]]);
    return {t[20:0], t[31:21]};
  endfunction

  function automatic logic [63:0] magma_model(input logic [63:0] blk, input logic encr);
    logic [31:0] a1, a0, tmp;
    int r, ki;
    a1 = blk[63:32];
    a0 = blk[31:0];
    for (int i = 0; i < 32; i++) begin
      r   = encr ? i : 31 - i;
      ki  = (r < 24) ? (r % 8) : (7 - (r % 8));
      tmp = g_fn(KEY[255 - 32*ki -: 32], a0) ^ a1;
      a1  = a0;
      a0  = tmp;
    end
    return {a0, a1};
  endfunction

  // ---------------- core stub ----------------
  logic        hang;
  int          lat;
  logic        stub_pend;
  int          stub_cnt;
  logic [63:0] stub_res;
  int          start_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stub_pend         <= 1'b0;
      stub_cnt          <= 0;
      stub_res          <= 64'd0;
      bus.core_done     <= 1'b0;
      bus.core_data_out <= 64'd0;
      start_cnt         <= 0;
    end else if (bus.core_start) begin
      start_cnt <= start_cnt + 1;
      stub_pend <= 1'b1;
      stub_cnt  <= lat;
      stub_res  <= magma_model(bus.core_data_in, bus.core_encr_decr);
    end else if (stub_pend) begin
      if (stub_cnt == 0) begin
        stub_pend         <= 1'b0;
        bus.core_done     <= ~hang;
        bus.core_data_out <= stub_res;
      end else begin
        bus.core_done <= 1'b0;
        stub_cnt      <= stub_cnt - 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec;
  int n_err;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks (enter and leave on a negedge) ----------------
  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_iv(input logic [63:0] v, input logic with_valid);
    bus.iv       = v;
    bus.iv_load  = 1'b1;
    bus.in_valid = with_valid;
    bus.in_data  = 64'h5555aaaa5555aaaa;
    #1;
    check("iv_load_blocks_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    bus.iv_load  = 1'b0;
    bus.in_valid = 1'b0;
    check("iv_load_not_busy", bus.busy, 1'b0);
    check("iv_load_chain", dbg_chain, v);
    check("iv_load_err_clr", bus.error, 1'b0);
  endtask

  task automatic do_block(input logic [63:0] d, input logic encr, input logic last,
                          input int stall, output logic [63:0] res);
    int n;
    int starts;
    logic [63:0] exp;
    starts       = start_cnt;
    bus.in_data  = d;
    bus.mode_encr = encr;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    #1;
    check("in_ready_idle", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("start_pulse", bus.core_start, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("out_valid", bus.out_valid, 1'b1);
    check("latency", 64'(n), 64'd5);
    res = bus.out_data;
    check("out_last", bus.out_last, last);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", bus.out_valid, 1'b1);
      check("stall_data", bus.out_data, res);
      check("stall_in_ready", bus.in_ready, 1'b0);
      check("stall_starts", 64'(start_cnt), 64'(starts + 1));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("idle_after_out", bus.in_ready, 1'b1);
    check("valid_drop", bus.out_valid, 1'b0);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check("out_data", res, exp);
    end else begin
      check("exp_q_nonempty", 64'd0, 64'd1);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [63:0] iv1, p1, p2, p3, c1, c2, c3, r, ce1, ce2, ce3, cm;
  int n;
  int wait_cycles;
  logic saw_valid;

  initial begin
    n_vec = 0;
    n_err = 0;
    hang  = 1'b0;
    lat   = 2;
    bus.mode_encr = 1'b0;
    bus.iv        = 64'd0;
    bus.iv_load   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 64'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    apply_reset();

    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_core_start", bus.core_start, 1'b0);
    check("rst_error", bus.error, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_chain", dbg_chain, 64'd0);

    // known-answer encrypt and decrypt with IV = 0
    load_iv(64'd0, 1'b0);
    exp_q.push_back(64'h4ee901e5c2d8ca3d);
    do_block(64'hfedcba9876543210, 1'b1, 1'b1, 0, r);
    check("kat_enc_chain_reset", dbg_chain, 64'd0);
    exp_q.push_back(64'hfedcba9876543210);
    do_block(64'h4ee901e5c2d8ca3d, 1'b0, 1'b1, 0, r);
    check("kat_dec_chain_reset", dbg_chain, 64'd0);

    // three-block message, iv_load racing an offered block
    iv1 = 64'h0123456789abcdef;
    p1  = 64'h1122334455667788;
    p2  = 64'h99aabbccddeeff00;
    p3  = 64'h0f1e2d3c4b5a6978;
    load_iv(iv1, 1'b1);
    ce1 = magma_model(p1 ^ iv1, 1'b1);
    ce2 = magma_model(p2 ^ ce1, 1'b1);
    ce3 = magma_model(p3 ^ ce2, 1'b1);
    exp_q.push_back(ce1);
    do_block(p1, 1'b1, 1'b0, 0, c1);
    check("chain_after_c1", dbg_chain, ce1);
    exp_q.push_back(ce2);
    do_block(p2, 1'b1, 1'b0, 0, c2);
    check("c2_is_e_p2_xor_c1", c2, magma_model(p2 ^ c1, 1'b1));
    exp_q.push_back(ce3);
    do_block(p3, 1'b1, 1'b1, 0, c3);
    check("chain_back_to_iv", dbg_chain, iv1);
    exp_q.push_back(p1);
    do_block(c1, 1'b0, 1'b0, 0, r);
    exp_q.push_back(p2);
    do_block(c2, 1'b0, 1'b0, 0, r);
    exp_q.push_back(p3);
    do_block(c3, 1'b0, 1'b1, 0, r);
    check("dec_chain_back_to_iv", dbg_chain, iv1);

    // mode switch inside one message
    cm = magma_model(p1 ^ iv1, 1'b1);
    exp_q.push_back(cm);
    do_block(p1, 1'b1, 1'b0, 0, r);
    exp_q.push_back(magma_model(p2, 1'b0) ^ cm);
    do_block(p2, 1'b0, 1'b1, 0, r);
    check("mixed_chain_back", dbg_chain, iv1);

    // output back-pressure for 10 cycles
    exp_q.push_back(magma_model(p3 ^ iv1, 1'b1));
    do_block(p3, 1'b1, 1'b1, 10, r);

    // hung core: watchdog fires after 255 WAIT cycles
    hang = 1'b1;
    bus.in_data   = p1;
    bus.mode_encr = 1'b1;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_cycles = 0;
    saw_valid   = 1'b0;
    n = 0;
    while (!bus.error && n < 400) begin
      @(negedge clk);
      n++;
      if (dbg_state == 2'd2) wait_cycles++;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check("hang_error", bus.error, 1'b1);
    check("hang_wait_cycles", 64'(wait_cycles), 64'd255);
    check("hang_no_out_valid", saw_valid, 1'b0);
    check("hang_idle_ready", bus.in_ready, 1'b1);
    check("hang_not_busy", bus.busy, 1'b0);
    check("hang_chain_iv", dbg_chain, iv1);
    hang = 1'b0;
    load_iv(iv1, 1'b0);

    // reset while the core is being waited on
    lat = 6;
    bus.in_data   = p2;
    bus.mode_encr = 1'b1;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("in_wait_before_reset", dbg_state, 2'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_core_start", bus.core_start, 1'b0);
    check("mid_rst_chain", dbg_chain, 64'd0);
    check("mid_rst_in_ready", bus.in_ready, 1'b1);
    lat = 2;
    exp_q.push_back(magma_model(p2, 1'b1));
    do_block(p2, 1'b1, 1'b1, 0, r);
    check("post_rst_chain", dbg_chain, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
